mmu_8722: RTL and testbench

- Register-file model of the C128 MMU. It is the upstream initiator of the mode/select lines that the PLA decoder consumes: ms0..ms3, z80en, z80io.
- It also produces translated address lines ta[15:8] and a RAM bank bit for page-0/page-1 relocation and common-RAM sharing.
- CPU-side bus is synchronous to the system clock: one-cycle access strobe, combinational read data.

---
 rtl/mmu_8722_if.sv | 28 ++
 rtl/mmu_8722.sv | 136 +++++++++++++
 tb/tb_mmu_8722.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mmu_8722_if.sv
// CPU-side bus and mode/translation outputs of the C128 MMU.
// master = CPU/bench side, slave = MMU side.
interface mmu_8722_if;
    logic        cyc;
    logic        rw;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_en;
    logic        ms0;
    logic        ms1;
    logic        ms2;
    logic        ms3;
    logic        z80en;
    logic        z80io;
    logic [7:0]  ta;
    logic        bank;

    modport master (
        output cyc, rw, a, din,
        input  dout, dout_en, ms0, ms1, ms2, ms3, z80en, z80io, ta, bank
    );

    modport slave (
        input  cyc, rw, a, din,
        output dout, dout_en, ms0, ms1, ms2, ms3, z80en, z80io, ta, bank
    );
endinterface

// File: rtl/mmu_8722.sv
// C128 MMU register file: CR/PCR/MCR/RCR/page pointers, ROM-select mux,
// common-RAM sharing and page-0/page-1 address translation.
module mmu_8722 #(
    parameter logic [7:0] VERSION = 8'h20
) (
    input logic         clk,
    input logic         rst_n,
    mmu_8722_if.slave   bus
);
    logic [7:0]  cr_q, mcr_q, rcr_q;
    logic [7:0]  pcr_q [4];
    logic [7:0]  p0l_q, p0h_q, p1l_q, p1h_q, p0hp_q, p1hp_q;

    logic        ms3;
    logic        ff_sel, d5_sel, wr_en, rd_en;
    logic [2:0]  ff_idx;
    logic [3:0]  d5_idx;
    logic [7:0]  rd_val;
    logic [15:0] cmn_size;
    logic        cmn_hit;
    logic [7:0]  hi;

    assign ms3    = ~mcr_q[6];
    assign hi     = bus.a[15:8];
    assign ff_sel = ms3 && (bus.a[15:3] == 13'h1FE0) && (bus.a[2:0] <= 3'd4);
    assign d5_sel = ms3 && !cr_q[0] && (bus.a[15:4] == 12'hD50) && (bus.a[3:0] <= 4'hB);
    assign wr_en  = bus.cyc & ~bus.rw;
    assign rd_en  = bus.cyc & bus.rw;
    assign ff_idx = bus.a[2:0] - 3'd1;
    assign d5_idx = bus.a[3:0] - 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q   <= 8'h00;
            mcr_q  <= 8'h00;
            rcr_q  <= 8'h00;
            p0l_q  <= 8'h00;
            p0h_q  <= 8'h00;
            p1l_q  <= 8'h01;
            p1h_q  <= 8'h00;
            p0hp_q <= 8'h00;
            p1hp_q <= 8'h00;
            for (int i = 0; i < 4; i++) pcr_q[i] <= 8'h00;
        end else if (wr_en && ff_sel) begin
            // FF01..FF04 load CR from the preconfiguration register; din unused
            if (bus.a[2:0] == 3'd0) cr_q <= bus.din;
            else                    cr_q <= pcr_q[ff_idx[1:0]];
        end else if (wr_en && d5_sel) begin
            case (bus.a[3:0])
                4'h0:                   cr_q <= bus.din;
                4'h1, 4'h2, 4'h3, 4'h4: pcr_q[d5_idx[1:0]] <= bus.din;
                4'h5:                   mcr_q <= bus.din;
                4'h6:                   rcr_q <= bus.din;
                4'h7: begin
                    p0l_q <= bus.din;
                    p0h_q <= p0hp_q;
                end
                4'h8:                   p0hp_q <= bus.din;
                4'h9: begin
                    p1l_q <= bus.din;
                    p1h_q <= p1hp_q;
                end
                4'hA:                   p1hp_q <= bus.din;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (ff_sel) begin
            rd_val = (bus.a[2:0] == 3'd0) ? cr_q : pcr_q[ff_idx[1:0]];
        end else begin
            case (bus.a[3:0])
                4'h0:                   rd_val = cr_q;
                4'h1, 4'h2, 4'h3, 4'h4: rd_val = pcr_q[d5_idx[1:0]];
                4'h5:                   rd_val = mcr_q;
                4'h6:                   rd_val = rcr_q;
                4'h7:                   rd_val = p0l_q;
                4'h8:                   rd_val = p0h_q;
                4'h9:                   rd_val = p1l_q;
                4'hA:                   rd_val = p1h_q;
                4'hB:                   rd_val = VERSION;
                default:                rd_val = 8'h00;
            endcase
        end
    end

    assign bus.dout_en = rd_en && (ff_sel || d5_sel);
    assign bus.dout    = bus.dout_en ? rd_val : 8'h00;
    assign bus.ms2     = cr_q[0];
    assign bus.ms3     = ms3;
    assign bus.z80en   = mcr_q[0];
    assign bus.z80io   = mcr_q[1];

    always_comb begin
        {bus.ms1, bus.ms0} = 2'b00;
        case (bus.a[15:14])
            2'b01:   {bus.ms1, bus.ms0} = {1'b0, cr_q[1]};
            2'b10:   {bus.ms1, bus.ms0} = cr_q[3:2];
            2'b11:   {bus.ms1, bus.ms0} = cr_q[5:4];
            default: {bus.ms1, bus.ms0} = 2'b00;
        endcase
    end

    always_comb begin
        case (rcr_q[1:0])
            2'b00:   cmn_size = 16'h0400;
            2'b01:   cmn_size = 16'h1000;
            2'b10:   cmn_size = 16'h2000;
            default: cmn_size = 16'h4000;
        endcase
    end

    // a >= 10000-size is the same test as (FFFF-a) < size, which stays in 16 bits
    assign cmn_hit = (rcr_q[2] && (bus.a < cmn_size)) ||
                     (rcr_q[3] && ((~bus.a) < cmn_size));

    always_comb begin
        bus.ta   = hi;
        bus.bank = cr_q[6];
        if (cmn_hit) begin
            bus.bank = 1'b0;
        end else if (hi == 8'h00) begin
            bus.ta   = p0l_q;
            bus.bank = p0h_q[0];
        end else if (hi == 8'h01) begin
            bus.ta   = p1l_q;
            bus.bank = p1h_q[0];
        end else if ((hi == p0l_q) && (cr_q[6] == p0h_q[0]) && (p0l_q != 8'h00)) begin
            bus.ta   = 8'h00;
        end else if ((hi == p1l_q) && (cr_q[6] == p1h_q[0]) && (p1l_q != 8'h01)) begin
            bus.ta   = 8'h01;
        end
    end
endmodule

// File: tb/tb_mmu_8722.sv
// Directed bench for mmu_8722: register access, ROM select, translation, reset.
module tb_mmu_8722;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [8:0] exp_q [$];

    mmu_8722_if bus_if ();
    mmu_8722 dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus_if.cyc = 1'b1; bus_if.rw = 1'b0; bus_if.a = addr; bus_if.din = data;
        @(negedge clk);
        bus_if.cyc = 1'b0; bus_if.rw = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic en, input logic [7:0] data);
        logic [8:0] e;
        @(negedge clk);
        bus_if.cyc = 1'b1; bus_if.rw = 1'b1; bus_if.a = addr;
        exp_q.push_back({en, data});
        #1;
        e = exp_q.pop_front();
        check(tag, {bus_if.dout_en, bus_if.dout}, e);
        bus_if.cyc = 1'b0;
    endtask

    task automatic xl(input string tag, input logic [15:0] addr, input logic [7:0] t, input logic b);
        @(negedge clk);
        bus_if.cyc = 1'b0; bus_if.a = addr;
        #1;
        check(tag, {bus_if.bank, bus_if.ta}, {b, t});
    endtask

    task automatic ms(input string tag, input logic [15:0] addr, input logic [2:0] exp);
        @(negedge clk);
        bus_if.cyc = 1'b0; bus_if.a = addr;
        #1;
        check(tag, {6'd0, bus_if.ms2, bus_if.ms1, bus_if.ms0}, {6'd0, exp});
    endtask

    initial begin
        bus_if.cyc = 1'b0; bus_if.rw = 1'b1; bus_if.a = 16'h1234; bus_if.din = 8'h00;
        #12 rst_n = 1'b1;
        #1;
        check("reset_mode", {5'd0, bus_if.ms3, bus_if.ms2, bus_if.z80en, bus_if.z80io}, 9'b0_0000_1000);
        check("reset_ta", {bus_if.bank, bus_if.ta}, {1'b0, 8'h12});
        rd("rd_cr_reset", 16'hFF00, 1'b1, 8'h00);
        rd("rd_version", 16'hD50B, 1'b1, 8'h20);
        rd("rd_p1l_reset", 16'hD509, 1'b1, 8'h01);

        wr(16'hD501, 8'h3E);
        wr(16'hFF01, 8'h00);
        rd("rd_cr_from_pcra", 16'hFF00, 1'b1, 8'h3E);
        rd("rd_pcra_ff01", 16'hFF01, 1'b1, 8'h3E);
        ms("ms_c000", 16'hC123, 3'b011);
        ms("ms_8000", 16'h8000, 3'b011);
        ms("ms_4000", 16'h4000, 3'b001);
        ms("ms_0000", 16'h2000, 3'b000);

        wr(16'hD508, 8'h01);
        rd("rd_p0h_pending", 16'hD508, 1'b1, 8'h00);
        wr(16'hD507, 8'h40);
        rd("rd_p0h_commit", 16'hD508, 1'b1, 8'h01);
        rd("rd_p0l", 16'hD507, 1'b1, 8'h40);
        xl("xl_page0", 16'h0012, 8'h40, 1'b1);
        xl("xl_noswap_bank", 16'h4012, 8'h40, 1'b0);
        xl("xl_page1", 16'h01AB, 8'h01, 1'b0);
        wr(16'hFF00, 8'h40);
        xl("xl_swap", 16'h4012, 8'h00, 1'b1);

        wr(16'hD506, 8'h05);
        xl("xl_cmn_bot_in", 16'h0F00, 8'h0F, 1'b0);
        xl("xl_cmn_bot_out", 16'h1000, 8'h10, 1'b1);
        xl("xl_cmn_over_p0", 16'h0012, 8'h00, 1'b0);
        wr(16'hD506, 8'h08);
        xl("xl_cmn_top_in", 16'hFC00, 8'hFC, 1'b0);
        xl("xl_cmn_top_out", 16'hFBFF, 8'hFB, 1'b1);

        wr(16'hFF00, 8'h01);
        rd("rd_d500_hidden", 16'hD500, 1'b0, 8'h00);
        rd("rd_ff00_visible", 16'hFF00, 1'b1, 8'h01);
        ms("ms2_set", 16'h0000, 3'b100);

        wr(16'hFF00, 8'h00);
        wr(16'hD505, 8'h43);
        #1;
        check("c64_mode", {5'd0, bus_if.ms3, bus_if.ms2, bus_if.z80en, bus_if.z80io}, 9'b0_0000_0011);
        wr(16'hFF00, 8'h3F);
        ms("ms_after_ign_wr", 16'hC000, 3'b000);
        rd("rd_c64_hidden", 16'hFF00, 1'b0, 8'h00);

        @(negedge clk);
        bus_if.cyc = 1'b1; bus_if.rw = 1'b1; bus_if.a = 16'hFF00;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_mode", {5'd0, bus_if.ms3, bus_if.ms2, bus_if.z80en, bus_if.z80io}, 9'b0_0000_1000);
        check("async_rst_cr", {bus_if.dout_en, bus_if.dout}, {1'b1, 8'h00});
        bus_if.a = 16'h0012;
        #1;
        check("async_rst_p0", {bus_if.bank, bus_if.ta}, {1'b0, 8'h00});
        bus_if.cyc = 1'b0;
        #3 rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
